// File: rtl/controle_venda_pkg.sv
// Shared constants for the vending controller: display modes,
// coin weights and the product price table.
package controle_venda_pkg;

  localparam logic [2:0] EST_DIGITACAO = 3'd0;
  localparam logic [2:0] EST_E404      = 3'd1;
  localparam logic [2:0] EST_E405      = 3'd2;
  localparam logic [2:0] EST_CREDITO   = 3'd3;
  localparam logic [2:0] EST_STANDBY   = 3'd4;

  localparam logic [4:0] PESO_25  = 5'd1;
  localparam logic [4:0] PESO_50  = 5'd2;
  localparam logic [4:0] PESO_100 = 5'd4;

  typedef struct packed {
    logic       existe;
    logic [3:0] preco;
  } preco_t;

  function automatic preco_t consulta_preco(
    input logic [3:0] codigo
  );
    preco_t r;
    r = '0;
    unique case (codigo)
      4'h5:    r = '{existe: 1'b1, preco: 4'd4};
      4'h6:    r = '{existe: 1'b1, preco: 4'd6};
      4'h9:    r = '{existe: 1'b1, preco: 4'd7};
      4'hA:    r = '{existe: 1'b1, preco: 4'd8};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/controle_venda_if.sv
// Keypad/coin/button inputs and display/mechanism outputs.
// master drives the events, slave is the controller.
interface controle_venda_if;
  logic       tecla_valida;
  logic [1:0] tecla;
  logic       moeda25;
  logic       moeda50;
  logic       moeda100;
  logic       confirmar;
  logic       cancelar;
  logic [2:0] estado;
  logic [1:0] num1;
  logic [1:0] num2;
  logic [3:0] valorMoedas;
  logic [3:0] produto;
  logic       liberar;
  logic       devolver;
  logic [3:0] troco;

  modport master (
    output tecla_valida, tecla,
    output moeda25, moeda50, moeda100,
    output confirmar, cancelar,
    input  estado, num1, num2, valorMoedas,
    input  produto, liberar, devolver, troco
  );

  modport slave (
    input  tecla_valida, tecla,
    input  moeda25, moeda50, moeda100,
    input  confirmar, cancelar,
    output estado, num1, num2, valorMoedas,
    output produto, liberar, devolver, troco
  );
endinterface

// File: rtl/controle_venda_temporizador.sv
// Error-screen timer: iniciar loads T_ERRO-1, parar aborts.
// fim is high in the last of the T_ERRO held cycles.
module temporizador_erro #(
  parameter int T_ERRO = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic iniciar,
  input  logic parar,
  output logic fim
);
  localparam int W =
    (T_ERRO > 1) ? $clog2(T_ERRO) : 1;

  logic [W-1:0] cnt;
  logic         ativo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      ativo <= 1'b0;
    end else if (parar) begin
      cnt   <= '0;
      ativo <= 1'b0;
    end else if (iniciar) begin
      cnt   <= W'(T_ERRO - 1);
      ativo <= 1'b1;
    end else if (ativo) begin
      if (cnt == '0) ativo <= 1'b0;
      else           cnt   <= cnt - W'(1);
    end
  end

  assign fim = ativo && (cnt == '0);
endmodule

// File: rtl/controle_venda.sv
// Vending-machine control FSM feeding the 4-digit display.
// Ports: clk, rst_n, bus (controle_venda_if.slave).
module controle_venda
  import controle_venda_pkg::*;
#(
  parameter int T_ERRO      = 50_000_000,
  parameter int CREDITO_MAX = 8
) (
  input logic             clk,
  input logic             rst_n,
  controle_venda_if.slave bus
);
  typedef enum logic [2:0] {
    S_STANDBY,
    S_DIG2,
    S_CREDITO,
    S_ERRO_PROD,
    S_ERRO_VALOR
  } fsm_t;

  fsm_t       state_q, state_d;
  logic [1:0] n1_q, n1_d, n2_q, n2_d;
  logic [3:0] cred_q, cred_d;
  logic [3:0] prod_q, prod_d;
  logic [3:0] troco_q, troco_d;
  logic       lib_q, lib_d, dev_q, dev_d;
  logic       iniciar, parar, fim;

  logic [4:0] soma, total;
  logic [3:0] diff;
  preco_t     sel, nova;

  temporizador_erro #(.T_ERRO(T_ERRO)) u_tmr (
    .clk     (clk),
    .rst_n   (rst_n),
    .iniciar (iniciar),
    .parar   (parar),
    .fim     (fim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_STANDBY;
      n1_q    <= '0;
      n2_q    <= '0;
      cred_q  <= '0;
      prod_q  <= '0;
      troco_q <= '0;
      lib_q   <= 1'b0;
      dev_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n1_q    <= n1_d;
      n2_q    <= n2_d;
      cred_q  <= cred_d;
      prod_q  <= prod_d;
      troco_q <= troco_d;
      lib_q   <= lib_d;
      dev_q   <= dev_d;
    end
  end

  always_comb begin
    soma = '0;
    if (bus.moeda25)  soma = soma + PESO_25;
    if (bus.moeda50)  soma = soma + PESO_50;
    if (bus.moeda100) soma = soma + PESO_100;
    total = {1'b0, cred_q} + soma;
    sel   = consulta_preco({n1_q, n2_q});
    nova  = consulta_preco({n1_q, bus.tecla});
    diff  = cred_q - sel.preco;
  end

  always_comb begin
    state_d = state_q;
    n1_d    = n1_q;
    n2_d    = n2_q;
    cred_d  = cred_q;
    prod_d  = '0;
    troco_d = '0;
    lib_d   = 1'b0;
    dev_d   = 1'b0;
    iniciar = 1'b0;
    parar   = 1'b0;

    if (bus.cancelar && state_q != S_STANDBY) begin
      if (cred_q != '0) begin
        dev_d   = 1'b1;
        troco_d = cred_q;
      end
      cred_d  = '0;
      n1_d    = '0;
      n2_d    = '0;
      parar   = 1'b1;
      state_d = S_STANDBY;
    end else begin
      unique case (state_q)
        S_STANDBY: begin
          if (bus.tecla_valida) begin
            n1_d    = bus.tecla;
            n2_d    = '0;
            state_d = S_DIG2;
          end
        end
        S_DIG2: begin
          if (bus.tecla_valida) begin
            n2_d = bus.tecla;
            if (nova.existe) begin
              cred_d  = '0;
              state_d = S_CREDITO;
            end else begin
              iniciar = 1'b1;
              state_d = S_ERRO_PROD;
            end
          end
        end
        S_CREDITO: begin
          if (bus.confirmar) begin
            if (sel.existe && cred_q >= sel.preco) begin
              lib_d   = 1'b1;
              prod_d  = {n1_q, n2_q};
              dev_d   = (diff != '0);
              troco_d = diff;
              cred_d  = '0;
              state_d = S_STANDBY;
            end else begin
              iniciar = 1'b1;
              state_d = S_ERRO_VALOR;
            end
          end else if (soma != '0) begin
            if (total <= 5'(CREDITO_MAX)) begin
              cred_d = total[3:0];
            end else begin
              dev_d   = 1'b1;
              troco_d = soma[3:0];
              iniciar = 1'b1;
              state_d = S_ERRO_VALOR;
            end
          end
        end
        S_ERRO_PROD: begin
          if (fim) begin
            n1_d    = '0;
            n2_d    = '0;
            state_d = S_STANDBY;
          end
        end
        S_ERRO_VALOR: begin
          // credit is frozen here; any coin goes straight back
          if (soma != '0) begin
            dev_d   = 1'b1;
            troco_d = soma[3:0];
          end
          if (fim) state_d = S_CREDITO;
        end
        default: state_d = S_STANDBY;
      endcase
    end
  end

  always_comb begin
    bus.estado = EST_STANDBY;
    unique case (state_q)
      S_STANDBY:    bus.estado = EST_STANDBY;
      S_DIG2:       bus.estado = EST_DIGITACAO;
      S_CREDITO:    bus.estado = EST_CREDITO;
      S_ERRO_PROD:  bus.estado = EST_E404;
      S_ERRO_VALOR: bus.estado = EST_E405;
      default:      bus.estado = EST_STANDBY;
    endcase
  end

  assign bus.num1        = n1_q;
  assign bus.num2        = n2_q;
  assign bus.valorMoedas = cred_q;
  assign bus.produto     = prod_q;
  assign bus.troco       = troco_q;
  assign bus.liberar     = lib_q;
  assign bus.devolver    = dev_q;
endmodule

// File: tb/tb_controle_venda.sv
// Directed bench for controle_venda with T_ERRO=8.
// Table rows: input byte then expected registered outputs.
module tb_controle_venda;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  controle_venda_if bus();

  controle_venda #(
    .T_ERRO      (8),
    .CREDITO_MAX (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0] est;
    logic [1:0] n1;
    logic [1:0] n2;
    logic [3:0] val;
    logic       lib;
    logic       dev;
    logic [3:0] tr;
    logic [3:0] pr;
  } obs_t;

  typedef struct packed {
    logic [7:0] in;
    obs_t       exp;
  } vec_t;

  // in: [7]key [6:5]digit [4]25 [3]50 [2]100 [1]conf [0]canc
  localparam logic [7:0] IDLE = 8'h00;
  localparam logic [7:0] M25  = 8'h10;
  localparam logic [7:0] M50  = 8'h08;
  localparam logic [7:0] M100 = 8'h04;
  localparam logic [7:0] CONF = 8'h02;
  localparam logic [7:0] CANC = 8'h01;

  vec_t tab[$];

  function automatic logic [7:0] key(input int d);
    return 8'h80 | 8'(d << 5);
  endfunction

  function automatic void add(
    input logic [7:0] in, input logic [2:0] est,
    input logic [1:0] n1, input logic [1:0] n2,
    input logic [3:0] val, input logic lib,
    input logic dev, input logic [3:0] tr,
    input logic [3:0] pr
  );
    vec_t v;
    v.in  = in;
    v.exp = '{est, n1, n2, val, lib, dev, tr, pr};
    tab.push_back(v);
  endfunction

  function automatic obs_t sample();
    return '{bus.estado, bus.num1, bus.num2,
             bus.valorMoedas, bus.liberar,
             bus.devolver, bus.troco, bus.produto};
  endfunction

  task automatic drive(input logic [7:0] in);
    {bus.tecla_valida, bus.tecla, bus.moeda25,
     bus.moeda50, bus.moeda100, bus.confirmar,
     bus.cancelar} = in;
  endtask

  task automatic check(input obs_t e, input string nm);
    obs_t a;
    a = sample();
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got est=%0d n=%0d%0d val=%0d lib=%0b dev=%0b tr=%0d pr=%0h want est=%0d n=%0d%0d val=%0d lib=%0b dev=%0b tr=%0d pr=%0h",
        nm, a.est, a.n1, a.n2, a.val, a.lib, a.dev,
        a.tr, a.pr, e.est, e.n1, e.n2, e.val, e.lib,
        e.dev, e.tr, e.pr);
    end
  endtask

  task automatic step(input vec_t v, input string nm);
    @(negedge clk);
    drive(v.in);
    @(posedge clk);
    #1;
    drive(IDLE);
    check(v.exp, nm);
  endtask

  initial begin
    drive(IDLE);

    // A: code 1,1 = 4'h5, price 4, exact payment
    add(key(1), 0, 1, 0, 0, 0, 0, 0, 0);
    add(key(1), 3, 1, 1, 0, 0, 0, 0, 0);
    add(M100,   3, 1, 1, 4, 0, 0, 0, 0);
    add(CONF,   4, 1, 1, 0, 1, 0, 0, 4'h5);
    add(IDLE,   4, 1, 1, 0, 0, 0, 0, 0);
    // B: code 2,1 = 4'h9, price 7, summed coins, change 1
    add(key(2), 0, 2, 0, 0, 0, 0, 0, 0);
    add(key(1), 3, 2, 1, 0, 0, 0, 0, 0);
    add(M100 | M50 | M25, 3, 2, 1, 7, 0, 0, 0, 0);
    add(M25,    3, 2, 1, 8, 0, 0, 0, 0);
    add(CONF,   4, 2, 1, 0, 1, 1, 1, 4'h9);
    add(IDLE,   4, 2, 1, 0, 0, 0, 0, 0);
    // C: code 0,0 missing, E404 held 8 cycles
    add(key(0), 0, 0, 0, 0, 0, 0, 0, 0);
    add(key(0), 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++)
      add((i == 2) ? key(3) : IDLE,
          1, 0, 0, 0, 0, 0, 0, 0);
    add(IDLE,   4, 0, 0, 0, 0, 0, 0, 0);
    add(M100,   4, 0, 0, 0, 0, 0, 0, 0);
    // D: code 2,2 = 4'hA, overflow coin rejected, E405
    add(key(2), 0, 2, 0, 0, 0, 0, 0, 0);
    add(key(2), 3, 2, 2, 0, 0, 0, 0, 0);
    add(M100,   3, 2, 2, 4, 0, 0, 0, 0);
    add(M50,    3, 2, 2, 6, 0, 0, 0, 0);
    add(M100,   2, 2, 2, 6, 0, 1, 4, 0);
    for (int i = 0; i < 7; i++) begin
      if (i == 2) add(M25, 2, 2, 2, 6, 0, 1, 1, 0);
      else        add(IDLE, 2, 2, 2, 6, 0, 0, 0, 0);
    end
    add(IDLE,   3, 2, 2, 6, 0, 0, 0, 0);
    add(key(1), 3, 2, 2, 6, 0, 0, 0, 0);
    add(CANC,   4, 0, 0, 0, 0, 1, 6, 0);
    // E: credit 5 short of 8, cancel mid-error
    add(key(2), 0, 2, 0, 0, 0, 0, 0, 0);
    add(key(2), 3, 2, 2, 0, 0, 0, 0, 0);
    add(M100,   3, 2, 2, 4, 0, 0, 0, 0);
    add(M25,    3, 2, 2, 5, 0, 0, 0, 0);
    add(CONF,   2, 2, 2, 5, 0, 0, 0, 0);
    add(M50,    2, 2, 2, 5, 0, 1, 2, 0);
    add(CANC,   4, 0, 0, 0, 0, 1, 5, 0);
    add(IDLE,   4, 0, 0, 0, 0, 0, 0, 0);
    // cancel with zero credit: no return pulse
    add(key(3), 0, 3, 0, 0, 0, 0, 0, 0);
    add(CANC,   4, 0, 0, 0, 0, 0, 0, 0);
    // cancel beats confirm in the same cycle
    add(key(1), 0, 1, 0, 0, 0, 0, 0, 0);
    add(key(1), 3, 1, 1, 0, 0, 0, 0, 0);
    add(M100,   3, 1, 1, 4, 0, 0, 0, 0);
    add(CONF | CANC, 4, 0, 0, 0, 0, 1, 4, 0);

    #12;
    check('{3'd4, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0,
            4'd0, 4'd0}, "reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tab[i])
      step(tab[i], $sformatf("vec%0d", i));

    // F: async reset mid-CREDITO with credit 3
    step('{key(1), '{3'd0, 2'd1, 2'd0, 4'd0, 1'b0,
           1'b0, 4'd0, 4'd0}}, "f_key1");
    step('{key(1), '{3'd3, 2'd1, 2'd1, 4'd0, 1'b0,
           1'b0, 4'd0, 4'd0}}, "f_key2");
    step('{M50 | M25, '{3'd3, 2'd1, 2'd1, 4'd3, 1'b0,
           1'b0, 4'd0, 4'd0}}, "f_cred3");
    #2;
    rst_n = 1'b0;
    #1;
    check('{3'd4, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0,
            4'd0, 4'd0}, "f_rst_async");
    @(posedge clk);
    #1;
    check('{3'd4, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0,
            4'd0, 4'd0}, "f_rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    step('{IDLE, '{3'd4, 2'd0, 2'd0, 4'd0, 1'b0,
           1'b0, 4'd0, 4'd0}}, "f_after");
    step('{key(2), '{3'd0, 2'd2, 2'd0, 4'd0, 1'b0,
           1'b0, 4'd0, 4'd0}}, "f_restart");

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
